md_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, sitting in the E stage beside the ALU of the five-stage pipeline. It accepts one operation at a time, raises `busy` for a fixed configurable latency, and commits the result to HI/LO on the final cycle. The hazard unit uses `start` and `busy` to stall any HI/LO-dependent or multiply/divide instruction held in D.

---
 rtl/md_unit.sv | 88 ++++++++
 tb/tb_md_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers; `MD_MACC_EN adds MADD/MADDU/MSUB/MSUBU.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] a_q, b_q, ua, ub, ud, uq, ur;
  logic [3:0] op_q;
  logic [2*WIDTH-1:0] ae, be, prod, res;
  logic macc_op, is_mul, is_div, is_div_q, sg, na, nb, last, load, commit;
`ifdef MD_MACC_EN
  assign macc_op = op >= 4'd7 && op <= 4'd10;
`else
  assign macc_op = 1'b0;
`endif
  assign is_mul = op == 4'd1 || op == 4'd2 || macc_op;
  assign is_div = op == 4'd3 || op == 4'd4;
  assign last = state == BUSY && cnt == CW'(1);
  // The commit edge doubles as the accept edge for a back-to-back op.
  assign load = (state == IDLE || last) && start && (is_mul || is_div);
  assign is_div_q = op_q == 4'd3 || op_q == 4'd4;
  assign commit = last && !(is_div_q && b_q == '0);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
      end
      if (commit) {hi, lo} <= res;
      else if (state == IDLE && start && op == 4'd5) hi <= A;
      else if (state == IDLE && start && op == 4'd6) lo <= A;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (state == BUSY) cnt_d = cnt - CW'(1);
    if (last) state_d = IDLE;
    if (load) begin
      state_d = BUSY;
      cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end
  end
  always_comb begin
    busy = state == BUSY;
    sg   = op_q == 4'd1 || op_q == 4'd3 || op_q == 4'd7 || op_q == 4'd9;
    ae   = sg ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    be   = sg ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod = ae * be;
    na   = sg && a_q[WIDTH-1];
    nb   = sg && b_q[WIDTH-1];
    ua   = na ? -a_q : a_q;
    ub   = nb ? -b_q : b_q;
    ud   = ub == '0 ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
    uq   = ua / ud;
    ur   = ua % ud;
    res  = is_div_q ? {na ? -ur : ur, (na ^ nb) ? -uq : uq} : prod;
`ifdef MD_MACC_EN
    if (op_q >= 4'd7) res = op_q >= 4'd9 ? {hi, lo} - prod : {hi, lo} + prod;
`endif
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit; commits are checked by a busy-fall monitor.
module tb_md_unit;
  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4,
                         MTHI = 4'd5, MTLO = 4'd6, MADD = 4'd7, MSUBU = 4'd10;
  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  logic clk = 0, reset, start, busy;
  logic [3:0] op;
  logic [31:0] A, B, hi, lo;
  exp_t sb[$];
  int checks = 0, failures = 0;
  int len = 0;
  logic prev = 0;

  md_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
               .busy(busy), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      len  = 0;
      prev = 0;
    end else begin
      if (busy) len++;
      else if (prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit actual hi=%h lo=%h required none", hi, lo);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_cycles"}, len, e.cyc);
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
        end
        len = 0;
      end
      prev = busy;
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1; op = o; A = a; B = b;
    @(negedge clk);
    start = 0; op = NONE;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, n >= 40, 0);
  endtask

  task automatic run(input string name, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int cyc, input logic [31:0] eh, input logic [31:0] el);
    sb.push_back('{name, cyc, eh, el});
    issue(o, a, b);
    wait_idle(name);
  endtask

  initial begin
    reset = 0; start = 0; op = NONE; A = 0; B = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1;
    run("mult", MULT, 32'hFFFFFFFE, 3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run("multu", MULTU, 32'hFFFFFFFE, 3, 5, 32'h00000002, 32'hFFFFFFFA);
    issue(MTLO, 32'h1234, 0);
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_hi", hi, 32'h2);
    chk("mtlo_busy", busy, 0);
    issue(MTHI, 32'hAA, 0);
    issue(MTLO, 32'hBB, 0);
    chk("mthi_hi", hi, 32'hAA);
    run("divu0", DIVU, 32'h1234, 0, 10, 32'hAA, 32'hBB);
    run("div_neg", DIV, 32'hFFFFFFF9, 2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("div_min", DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    run("div_negb", DIV, 7, 32'hFFFFFFFE, 10, 32'h1, 32'hFFFFFFFD);
    run("divu", DIVU, 100, 7, 10, 32'h2, 32'hE);
    sb.push_back('{"div_ign", 10, 32'hFFFFFFFE, 32'hFFFFFFF2});
    issue(DIV, 32'hFFFFFF9C, 7);
    @(negedge clk);
    issue(MULT, 2, 2);
    issue(MTHI, 5, 0);
    chk("ign_mthi_hi", hi, 32'h2);
    chk("ign_busy", busy, 1);
    wait_idle("div_ign");
    issue(DIV, 100, 7);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk);
    reset = 1;
    repeat (15) @(negedge clk);
    chk("abort_late_hi", hi, 0);
    chk("abort_late_lo", lo, 0);
    chk("abort_late_busy", busy, 0);
    issue(MTLO, 1, 0);
`ifdef MD_MACC_EN
    run("madd", MADD, 2, 3, 5, 32'h0, 32'h7);
    run("msubu", MSUBU, 1, 8, 5, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    issue(MADD, 2, 3);
    chk("madd_off_busy", busy, 0);
    issue(MSUBU, 1, 8);
    chk("msubu_off_busy", busy, 0);
    repeat (8) @(negedge clk);
    chk("macc_off_hi", hi, 0);
    chk("macc_off_lo", lo, 1);
`endif
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
